// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch/jump resolution with registered PC redirect,
//               flush and a 2-bit branch history table for fetch prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_cmp_result,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      r_bht [BHT_ENTRIES];
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_fire;
    logic             w_is_jalr;
    logic             w_is_jal;
    logic             w_is_br;
    logic             w_taken;
    logic             w_need_redirect;
    logic [XLEN-1:0]  w_pc_imm;
    logic [XLEN-1:0]  w_rs1_imm;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_target;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_next;
    logic             w_unused_bits;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Illegal multi-flag decodes resolve as jalr > jal > branch.
    assign w_is_jalr = ex_is_jalr;
    assign w_is_jal  = ex_is_jal & ~ex_is_jalr;
    assign w_is_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

    // Instructions in EX while a redirect is pending are wrong-path.
    assign w_fire  = ex_valid & ~stall & ~r_redirect_valid;
    assign w_taken = w_is_jal | w_is_jalr | (w_is_br & ex_cmp_result);

    assign w_pc_imm   = ex_pc + ex_imm;
    assign w_rs1_imm  = ex_rs1 + ex_imm;
    assign w_pc_plus4 = ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

    always_comb begin
        w_target        = w_pc_imm;
        w_need_redirect = 1'b0;
        if (w_is_jalr) begin
            w_target        = {w_rs1_imm[XLEN-1:1], 1'b0};
            w_need_redirect = w_fire;
        end else if (w_is_jal) begin
            w_need_redirect = w_fire;
        end else if (w_is_br) begin
            w_need_redirect = w_fire & (w_taken ^ ex_pred_taken);
            if (!w_taken) begin
                w_target = w_pc_plus4;
            end
        end
    end

    assign w_ctr_cur = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (w_taken && w_ctr_cur != 2'b11) begin
            w_ctr_next = w_ctr_cur + 2'b01;
        end else if (!w_taken && w_ctr_cur != 2'b00) begin
            w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_fire && w_is_br) begin
            r_bht[w_ex_idx] <= w_ctr_next;
        end
    end

    // A pending redirect holds through stalls and drops on the first free edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_count          <= '0;
        end else if (w_need_redirect) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
            r_count          <= r_count + 32'd1;
        end else if (r_redirect_valid && !stall) begin
            r_redirect_valid <= 1'b0;
        end
    end

    assign redirect_valid   = r_redirect_valid;
    assign flush            = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign mispredict_count = r_count;

    assign w_unused_bits = &{1'b0, if_pc[XLEN-1:IDX_W+2], if_pc[1:0], w_rs1_imm[0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed vector table plus stall and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_cmp_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jal        (ex_is_jal),
        .ex_is_jalr       (ex_is_jalr),
        .ex_cmp_result    (ex_cmp_result),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_rs1           (ex_rs1),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        jal;
        logic        jalr;
        logic        cmp;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic [31:0] look_pc;
        logic        exp_pred;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_redirect(input string tag, input logic rv, input logic [31:0] pc,
                                  input logic [31:0] cnt);
        check({tag, " redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, " flush"}, {31'd0, flush}, {31'd0, rv});
        if (rv) check({tag, " redirect_pc"}, redirect_pc, pc);
        check({tag, " count"}, mispredict_count, cnt);
    endtask

    task automatic drive_ex(input logic br, input logic jal, input logic jalr, input logic cmp,
                            input logic pred, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1);
        ex_valid      = 1'b1;
        ex_is_branch  = br;
        ex_is_jal     = jal;
        ex_is_jalr    = jalr;
        ex_cmp_result = cmp;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rs1        = rs1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check({tag, " if_pred_taken"}, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        //             br   jal  jalr cmp  pred pc            imm           rs1           rv   exp_pc        cnt look          pred
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0200,32'h0000_0040,32'h0,        1'b1,32'h0000_0240,32'd1,32'h0000_0200,1'b1};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h0000_0300,32'h0000_0080,32'h0,        1'b1,32'h0000_0304,32'd2,32'h0000_0300,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0300,32'h0000_0080,32'h0,        1'b0,32'h0,        32'd2,32'h0000_0300,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0300,32'h0000_0080,32'h0,        1'b0,32'h0,        32'd2,32'h0000_0300,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0300,32'h0000_0080,32'h0,        1'b1,32'h0000_0380,32'd3,32'h0000_0300,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0400,32'h0000_0010,32'h0000_1001,1'b1,32'h0000_1010,32'd4,32'h0000_0400,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFF0,32'h0000_0020,32'h0,        1'b1,32'h0000_0010,32'd5,32'hFFFF_FFF0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0404,32'h0000_0100,32'h0,        1'b0,32'h0,        32'd5,32'h0000_0404,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_0208,32'h0000_0020,32'h0,        1'b0,32'h0,        32'd5,32'h0000_0208,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_0208,32'h0000_0020,32'h0,        1'b0,32'h0,        32'd5,32'h0000_0208,1'b1};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h0000_0208,32'h0000_0020,32'h0,        1'b1,32'h0000_020C,32'd6,32'h0000_0208,1'b1};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0000_0500,32'h0000_0004,32'h0000_2000,1'b1,32'h0000_2004,32'd7,32'h0000_0104,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h0000_0600,32'h0000_0100,32'h0,        1'b1,32'h0000_0700,32'd8,32'h0000_0104,1'b0};

        rst_n = 1'b0;
        stall = 1'b0;
        if_pc = 32'h100;
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lookup("reset", 32'h100, 1'b0);
        check_redirect("reset", 1'b0, 32'h0, 32'd0);

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive_ex(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].cmp, vecs[i].pred,
                     vecs[i].pc, vecs[i].imm, vecs[i].rs1);
            @(posedge clk);
            #1;
            check_redirect(tag, vecs[i].exp_rv, vecs[i].exp_pc, vecs[i].exp_cnt);
            ex_valid = 1'b0;
            @(posedge clk);
            #1;
            check({tag, " pulse end"}, {31'd0, redirect_valid}, 32'd0);
            lookup(tag, vecs[i].look_pc, vecs[i].exp_pred);
        end

        // Stalled redirect holds; wrong-path branch in EX is ignored.
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h210, 32'h30, 32'h0);
        @(posedge clk);
        #1;
        check_redirect("stall issue", 1'b1, 32'h240, 32'd9);
        stall = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h214, 32'h8, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_redirect($sformatf("stall hold%0d", c), 1'b1, 32'h240, 32'd9);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_redirect("stall release", 1'b0, 32'h0, 32'd9);
        ex_valid = 1'b0;
        lookup("wrong path", 32'h214, 1'b0);
        lookup("stall branch", 32'h210, 1'b1);

        // Async reset while a redirect is pending.
        @(negedge clk);
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check_redirect("pre-reset", 1'b1, 32'h840, 32'd10);
        #1;
        rst_n = 1'b0;
        #1;
        check("async redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("async flush", {31'd0, flush}, 32'd0);
        check("async redirect_pc", redirect_pc, 32'h0);
        check("async count", mispredict_count, 32'd0);
        lookup("async bht 0x208", 32'h208, 1'b0);
        lookup("async bht 0x210", 32'h210, 1'b0);
        lookup("async bht 0x200", 32'h200, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_redirect("post-reset", 1'b0, 32'h0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
